// File: rtl/pc_sequencer_param_pkg.sv
// Shared definitions for the parametrised fetch-stage program counter:
// instruction kind encodings and the delay-pipe entry layout.
package pc_sequencer_param_pkg;

  typedef enum logic [1:0] {
    KIND_SEQ  = 2'b00,
    KIND_JUMP = 2'b01,
    KIND_CALL = 2'b10,
    KIND_RET  = 2'b11
  } kind_e;

  // Entry targets are sized for the widest supported PC (ADDR_W <= 64).
  localparam int PIPE_TGT_W = 64;

  typedef struct packed {
    logic                  valid;
    logic [PIPE_TGT_W-1:0] target;
  } pipe_entry_t;

endpackage

// File: rtl/pc_sequencer_param_return_stack_ring.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// A pop when empty changes nothing. Both cases set sticky flags.
module return_stack_ring #(
  parameter int ADDR_W      = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             do_push,
  input  logic                             do_pop,
  input  logic [ADDR_W-1:0]                push_data,
  output logic [ADDR_W-1:0]                top,
  output logic [$clog2(STACK_DEPTH+1)-1:0] count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH+1);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]  top_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STACK_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(STACK_DEPTH-1) : p - PTR_W'(1);
  endfunction

  assign top = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[ptr_inc(top_ptr)] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_ptr   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (do_push) begin
      top_ptr <= ptr_inc(top_ptr);
      if (count == CNT_W'(STACK_DEPTH)) overflow <= 1'b1;
      else                              count    <= count + CNT_W'(1);
    end else if (do_pop) begin
      if (count == '0) begin
        underflow <= 1'b1;
      end else begin
        top_ptr <= ptr_dec(top_ptr);
        count   <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer_param.sv
// Fetch-stage PC sequencer: immediate jump/call/return, delayed branch and
// register-jump redirects with flush of younger pending redirects.
module pc_sequencer_param
  import pc_sequencer_param_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                STACK_DEPTH  = 8,
  parameter int                BR_DELAY     = 2,
  parameter int                JR_DELAY     = 1,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             keep_pc,
  input  logic [1:0]                       kind,
  input  logic [ADDR_W-1:0]                target,
  input  logic                             is_branch,
  input  logic                             is_jump_reg,
  input  logic                             branch_taken,
  input  logic [ADDR_W-1:0]                rs_value,
  output logic [ADDR_W-1:0]                pc,
  output logic                             stack_overflow,
  output logic                             stack_underflow,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count
);

  pipe_entry_t         br_q [BR_DELAY];
  logic [JR_DELAY-1:0] jr_q;
  logic [BR_DELAY-1:0] br_keep;
  logic [JR_DELAY-1:0] jr_keep;
  logic                br_fire, jr_fire, issue;
  logic                do_push, do_pop;
  logic [ADDR_W-1:0]   pc_next, stack_top;

  assign br_fire = br_q[BR_DELAY-1].valid && branch_taken;
  assign jr_fire = jr_q[JR_DELAY-1];
  assign issue   = !keep_pc && !br_fire && !jr_fire;

  // Entry i of either pipe was issued i+1 cycles ago; anything issued after
  // the firing instruction is dropped.
  always_comb begin
    br_keep = '1;
    jr_keep = '1;
    if (br_fire) begin
      for (int i = 0; i < BR_DELAY; i++) if (i < BR_DELAY-1) br_keep[i] = 1'b0;
      for (int i = 0; i < JR_DELAY; i++) if (i < BR_DELAY-1) jr_keep[i] = 1'b0;
    end else if (jr_fire) begin
      for (int i = 0; i < BR_DELAY; i++) if (i < JR_DELAY-1) br_keep[i] = 1'b0;
      for (int i = 0; i < JR_DELAY; i++) if (i < JR_DELAY-1) jr_keep[i] = 1'b0;
    end
  end

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (br_fire) begin
      pc_next = ADDR_W'(br_q[BR_DELAY-1].target);
    end else if (jr_fire) begin
      pc_next = rs_value;
    end else if (keep_pc) begin
      pc_next = pc;
    end else begin
      case (kind_e'(kind))
        KIND_JUMP: pc_next = target;
        KIND_CALL: begin
          pc_next = target;
          do_push = 1'b1;
        end
        KIND_RET: begin
          do_pop = 1'b1;
          if (stack_count != '0) pc_next = stack_top;
        end
        default: ;
      endcase
    end
  end

  // Stage boundary: PC register and redirect tag pipes
  always_ff @(posedge clk) begin
    for (int i = BR_DELAY-1; i > 0; i--) br_q[i].target <= br_q[i-1].target;
    br_q[0].target <= PIPE_TGT_W'(target);
    if (reset) begin
      pc   <= RESET_VECTOR;
      jr_q <= '0;
      for (int i = 0; i < BR_DELAY; i++) br_q[i].valid <= 1'b0;
    end else begin
      pc <= pc_next;
      for (int i = BR_DELAY-1; i > 0; i--) br_q[i].valid <= br_q[i-1].valid && br_keep[i-1];
      br_q[0].valid <= issue && is_branch;
      for (int i = JR_DELAY-1; i > 0; i--) jr_q[i] <= jr_q[i-1] && jr_keep[i-1];
      jr_q[0] <= issue && is_jump_reg;
    end
  end

  return_stack_ring #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .do_push   (do_push),
    .do_pop    (do_pop),
    .push_data (pc + ADDR_W'(1)),
    .top       (stack_top),
    .count     (stack_count),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

endmodule

// File: tb/tb_pc_sequencer_param.sv
// Scoreboard bench for pc_sequencer_param: two instances (32-bit, depth 2;
// 8-bit with wrap, JR_DELAY 2) driven with directed vectors.
module tb_pc_sequencer_param;

  localparam logic [1:0] K_SEQ = 2'b00, K_JMP = 2'b01, K_CALL = 2'b10, K_RET = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_keep, a_isb, a_isj, a_bt, a_ovf, a_unf;
  logic [1:0]  a_kind, a_cnt;
  logic [31:0] a_target, a_rs, a_pc;

  logic        b_keep, b_isb, b_isj, b_bt, b_ovf, b_unf;
  logic [1:0]  b_kind;
  logic [3:0]  b_cnt;
  logic [7:0]  b_target, b_rs, b_pc;

  pc_sequencer_param #(.ADDR_W(32), .STACK_DEPTH(2), .BR_DELAY(2), .JR_DELAY(1)) u_a (
    .clk(clk), .reset(reset), .keep_pc(a_keep), .kind(a_kind), .target(a_target),
    .is_branch(a_isb), .is_jump_reg(a_isj), .branch_taken(a_bt), .rs_value(a_rs),
    .pc(a_pc), .stack_overflow(a_ovf), .stack_underflow(a_unf), .stack_count(a_cnt));

  pc_sequencer_param #(.ADDR_W(8), .STACK_DEPTH(8), .BR_DELAY(2), .JR_DELAY(2),
                       .RESET_VECTOR(8'hFE)) u_b (
    .clk(clk), .reset(reset), .keep_pc(b_keep), .kind(b_kind), .target(b_target),
    .is_branch(b_isb), .is_jump_reg(b_isj), .branch_taken(b_bt), .rs_value(b_rs),
    .pc(b_pc), .stack_overflow(b_ovf), .stack_underflow(b_unf), .stack_count(b_cnt));

  typedef struct {
    int          due;
    int          dut;
    logic [31:0] pc;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cycnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cycnt <= cycnt + 1;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", what, cycnt, act, req);
    end
  endtask

  // Monitor: compares every expectation due by the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cycnt) begin
        e = sb.pop_front();
        if (e.dut == 0) begin
          check("A.pc",  a_pc,         e.pc);
          check("A.cnt", 32'(a_cnt),   32'(e.cnt));
          check("A.ovf", 32'(a_ovf),   32'(e.ovf));
          check("A.unf", 32'(a_unf),   32'(e.unf));
        end else begin
          check("B.pc",  32'(b_pc),    e.pc);
          check("B.cnt", 32'(b_cnt),   32'(e.cnt));
          check("B.ovf", 32'(b_ovf),   32'(e.ovf));
          check("B.unf", 32'(b_unf),   32'(e.unf));
        end
      end
    end
  end

  task automatic expect_now(input int d, input logic [31:0] epc, input int ecnt,
                            input logic eovf, input logic eunf, input int lag);
    sb.push_back('{due: cycnt + lag, dut: d, pc: epc, cnt: ecnt, ovf: eovf, unf: eunf});
  endtask

  // Drive one cycle of inputs for DUT d and queue the state expected after the edge.
  task automatic tick(input int d, input logic keep, input logic [1:0] kind,
                      input logic [31:0] tgt, input logic isb, input logic isj,
                      input logic bt, input logic [31:0] rs,
                      input logic [31:0] epc, input int ecnt, input logic eovf, input logic eunf);
    if (d == 0) begin
      a_keep = keep; a_kind = kind; a_target = tgt; a_isb = isb; a_isj = isj;
      a_bt = bt; a_rs = rs;
    end else begin
      b_keep = keep; b_kind = kind; b_target = tgt[7:0]; b_isb = isb; b_isj = isj;
      b_bt = bt; b_rs = rs[7:0];
    end
    expect_now(d, epc, ecnt, eovf, eunf, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_keep = 1'b1; a_kind = K_SEQ; a_target = '0; a_isb = 0; a_isj = 0; a_bt = 0; a_rs = '0;
    b_keep = 1'b1; b_kind = K_SEQ; b_target = '0; b_isb = 0; b_isj = 0; b_bt = 0; b_rs = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_now(0, 32'd0, 0, 0, 0, 0);
    expect_now(1, 32'hFE, 0, 0, 0, 0);

    // DUT A: sequential run and stall
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   2, 0, 0, 0);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   3, 0, 0, 0);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   4, 0, 0, 0);
    tick(0, 1, K_SEQ, 0, 0, 0, 0, 0,   4, 0, 0, 0);
    tick(0, 1, K_SEQ, 0, 0, 0, 0, 0,   4, 0, 0, 0);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   5, 0, 0, 0);
    // call/return
    tick(0, 0, K_JMP, 10, 0, 0, 0, 0,  10, 0, 0, 0);
    tick(0, 0, K_CALL, 100, 0, 0, 0, 0, 100, 1, 0, 0);
    tick(0, 0, K_RET, 0, 0, 0, 0, 0,   11, 0, 0, 0);
    // overflow/underflow with depth 2
    tick(0, 0, K_JMP, 1, 0, 0, 0, 0,   1, 0, 0, 0);
    tick(0, 0, K_CALL, 20, 0, 0, 0, 0, 20, 1, 0, 0);
    tick(0, 0, K_JMP, 21, 0, 0, 0, 0,  21, 1, 0, 0);
    tick(0, 0, K_CALL, 40, 0, 0, 0, 0, 40, 2, 0, 0);
    tick(0, 0, K_JMP, 41, 0, 0, 0, 0,  41, 2, 0, 0);
    tick(0, 0, K_CALL, 60, 0, 0, 0, 0, 60, 2, 1, 0);
    tick(0, 0, K_RET, 0, 0, 0, 0, 0,   42, 1, 1, 0);
    tick(0, 0, K_RET, 0, 0, 0, 0, 0,   22, 0, 1, 0);
    tick(0, 0, K_RET, 0, 0, 0, 0, 0,   23, 0, 1, 1);
    // taken branch after a younger call that still pushes
    tick(0, 0, K_JMP, 5, 0, 0, 0, 0,   5, 0, 1, 1);
    tick(0, 0, K_SEQ, 50, 1, 0, 0, 0,  6, 0, 1, 1);
    tick(0, 0, K_CALL, 30, 0, 0, 0, 0, 30, 1, 1, 1);
    tick(0, 0, K_SEQ, 0, 0, 0, 1, 0,   50, 1, 1, 1);
    // branch and jr fire together: branch wins, the pending call is not pushed
    tick(0, 0, K_JMP, 5, 0, 0, 0, 0,   5, 1, 1, 1);
    tick(0, 0, K_SEQ, 50, 1, 0, 0, 0,  6, 1, 1, 1);
    tick(0, 0, K_SEQ, 0, 0, 1, 0, 0,   7, 1, 1, 1);
    tick(0, 0, K_CALL, 77, 0, 0, 1, 200, 50, 1, 1, 1);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   51, 1, 1, 1);
    // plain register jump, then a not-taken branch
    tick(0, 0, K_SEQ, 0, 0, 1, 0, 0,   52, 1, 1, 1);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 300, 300, 1, 1, 1);
    tick(0, 0, K_SEQ, 9, 1, 0, 0, 0,   301, 1, 1, 1);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   302, 1, 1, 1);
    tick(0, 0, K_SEQ, 0, 0, 0, 0, 0,   303, 1, 1, 1);
    a_keep = 1'b1; a_isb = 0; a_isj = 0; a_bt = 0;

    // DUT B: 8-bit wrap
    tick(1, 0, K_SEQ, 0, 0, 0, 0, 0,   32'hFF, 0, 0, 0);
    tick(1, 0, K_SEQ, 0, 0, 0, 0, 0,   32'h00, 0, 0, 0);
    // taken branch flushes a younger pending jr
    tick(1, 0, K_JMP, 5, 0, 0, 0, 0,   5, 0, 0, 0);
    tick(1, 0, K_SEQ, 50, 1, 0, 0, 0,  6, 0, 0, 0);
    tick(1, 0, K_SEQ, 0, 0, 1, 0, 0,   7, 0, 0, 0);
    tick(1, 0, K_SEQ, 0, 0, 0, 1, 0,   50, 0, 0, 0);
    tick(1, 0, K_SEQ, 0, 0, 0, 0, 200, 51, 0, 0, 0);
    tick(1, 0, K_SEQ, 0, 0, 0, 0, 0,   52, 0, 0, 0);
    // jr fire flushes a younger pending branch
    tick(1, 0, K_SEQ, 0, 0, 1, 0, 0,   53, 0, 0, 0);
    tick(1, 0, K_SEQ, 99, 1, 0, 0, 0,  54, 0, 0, 0);
    tick(1, 0, K_SEQ, 0, 0, 0, 0, 120, 120, 0, 0, 0);
    tick(1, 0, K_SEQ, 0, 0, 0, 1, 0,   121, 0, 0, 0);
    tick(1, 0, K_CALL, 200, 0, 0, 0, 0, 200, 1, 0, 0);
    tick(1, 0, K_RET, 0, 0, 0, 0, 0,   122, 0, 0, 0);
    b_keep = 1'b1; b_isb = 0; b_isj = 0; b_bt = 0;

    // Reset mid-stream overrides a jump and clears sticky flags
    reset = 1'b1;
    a_keep = 1'b0; a_kind = K_JMP; a_target = 32'd77;
    expect_now(0, 32'd0, 0, 0, 0, 1);
    expect_now(1, 32'hFE, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_keep = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
